// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding and forwarding
// mux select codes, plus the forwarding priority helper.
package cpu_pkg;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_WAIT    = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_t;

    // ALU operand source selects
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    // Pick the youngest in-flight producer of src; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_addr,
        input logic       wb_we,
        input logic [4:0] wb_addr
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (src != 5'd0) begin
            if (mem_we && (mem_addr == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_we && (wb_addr == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker. An accepted issue loads MD_LATENCY-1 and
// raises busy on the next cycle; busy falls the cycle after the count
// has reached zero, so busy is high for MD_LATENCY cycles in total.
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count_q;

    // Load on issue, then count down while busy; reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            busy    <= 1'b0;
        end else if (start && !busy) begin
            count_q <= LOAD_VAL;
            busy    <= 1'b1;
        end else if (busy) begin
            if (count_q == '0) begin
                busy <= 1'b0;
            end else begin
                count_q <= count_q - ONE;
            end
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, mult/div wait, taken-branch
// flush and operand forwarding. Outputs are decoded combinationally from the
// registered state and the current stage inputs. dbg_state exposes the FSM.
module hazard_control
    import cpu_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_muldiv,
    input  logic       id_reads_hilo,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_addr,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_write_addr,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_write_addr,
    input  logic       ex_branch_taken,
    output logic       pc_write_en,
    output logic       ifid_write_en,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       md_busy,
    output logic [1:0] dbg_state
);

    hz_state_t state_q;
    hz_state_t state_d;

    logic load_use;
    logic md_hazard;
    logic pc_we_c;
    logic ifid_we_c;
    logic bubble_c;
    logic flush_c;
    logic md_start;

    // A load in EX whose destination feeds a used decode operand. ex_reg_write
    // is implied by ex_mem_read, and $0 never creates a dependency.
    always_comb begin
        load_use = ex_mem_read && (ex_write_addr != 5'd0) &&
                   ((id_uses_rs && (id_rs_addr == ex_write_addr)) ||
                    (id_uses_rt && (id_rt_addr == ex_write_addr)));
        md_hazard = (id_reads_hilo || id_is_muldiv) && md_busy;
    end

    // Next state and stage controls; a taken branch overrides every stall,
    // and reset forces the pipeline to free-run with no forwarding.
    always_comb begin
        state_d   = ST_RUN;
        pc_we_c   = 1'b1;
        ifid_we_c = 1'b1;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        case (state_q)
            ST_RUN, ST_MD_WAIT: begin
                if (md_hazard) begin
                    pc_we_c   = 1'b0;
                    ifid_we_c = 1'b0;
                    bubble_c  = 1'b1;
                    state_d   = ST_MD_WAIT;
                end else if (load_use) begin
                    pc_we_c   = 1'b0;
                    ifid_we_c = 1'b0;
                    bubble_c  = 1'b1;
                    state_d   = ST_LOAD_STALL;
                end
            end
            default: begin
                // LOAD_STALL and FLUSH are single idle cycles back to RUN
                state_d = ST_RUN;
            end
        endcase
        if (ex_branch_taken) begin
            pc_we_c   = 1'b1;
            ifid_we_c = 1'b1;
            bubble_c  = 1'b1;
            flush_c   = 1'b1;
            state_d   = ST_FLUSH;
        end
        if (!rst_n) begin
            pc_we_c   = 1'b1;
            ifid_we_c = 1'b1;
            bubble_c  = 1'b0;
            flush_c   = 1'b0;
        end
    end

    // Operand forwarding selects, EX/MEM beats MEM/WB
    always_comb begin
        fwd_a_sel = FWD_REGFILE;
        fwd_b_sel = FWD_REGFILE;
        if (rst_n) begin
            fwd_a_sel = fwd_select(id_rs_addr, mem_reg_write, mem_write_addr,
                                   wb_reg_write, wb_write_addr);
            fwd_b_sel = fwd_select(id_rt_addr, mem_reg_write, mem_write_addr,
                                   wb_reg_write, wb_write_addr);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A mult/div only issues when it actually advances into EX this cycle
    assign md_start = id_is_muldiv && !md_busy && !bubble_c;

    md_busy_counter #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_busy_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .start(md_start),
        .busy (md_busy)
    );

    assign pc_write_en   = pc_we_c;
    assign ifid_write_en = ifid_we_c;
    assign idex_bubble   = bubble_c;
    assign ifid_flush    = flush_c;
    assign dbg_state     = state_q;

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32, giving the mult/div busy cycles counted from the issue cycle.
REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs_addr, id_rt_addr  input  5 each  source register fields of the instruction in decode.
REQ-005 SHALL have ports id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo  input  1 each  decode operand-use and class flags.
REQ-006 SHALL have ports ex_reg_write, ex_mem_read  input  1 each, and ex_write_addr  input  5  execute-stage destination info.
REQ-007 SHALL have ports mem_reg_write  input  1, and mem_write_addr  input  5  memory-stage destination info.
REQ-008 SHALL have ports wb_reg_write  input  1, and wb_write_addr  input  5  writeback destination info.
REQ-009 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in execute.
REQ-010 SHALL have ports pc_write_en, ifid_write_en  output  1 each  stage-hold enables.
REQ-011 SHALL have ports idex_bubble, ifid_flush  output  1 each  insert NOP into ID/EX; squash IF/ID.
REQ-012 SHALL have ports fwd_a_sel, fwd_b_sel  output  2 each  ALU operand source: 0 regfile, 1 EX/MEM, 2 MEM/WB.
REQ-013 SHALL have port md_busy  output  1  mult/div unit occupied.

Function
REQ-014 SHALL implement FSM states RUN, LOAD_STALL, MD_WAIT, FLUSH, registered, combinational outputs decoded from state and inputs.
REQ-015 Load-use: in RUN, if ex_mem_read, ex_write_addr != 0, and ex_write_addr matches a used id source -> pc_write_en=0, ifid_write_en=0, idex_bubble=1 that cycle, next state LOAD_STALL.
REQ-016 LOAD_STALL SHALL last exactly one cycle with pc_write_en=ifid_write_en=1, idex_bubble=0, then return to RUN.
REQ-017 Mult/div: id_is_muldiv accepted while !md_busy SHALL load a counter with MD_LATENCY-1 and set md_busy next cycle; counter decrements each cycle; md_busy clears when counter reaches 0.
REQ-018 id_reads_hilo or id_is_muldiv while md_busy SHALL enter/stay MD_WAIT: stall IF/ID, bubble ID/EX, until md_busy clears; release in the cycle md_busy is 0.
REQ-019 ex_branch_taken SHALL take priority over all stalls: ifid_flush=1, idex_bubble=1, pc_write_en=1 that cycle; next state FLUSH (one cycle, outputs idle), then RUN; md counter unaffected.
REQ-020 Forwarding per operand: EX/MEM match (mem_reg_write, addr != 0) -> 1; else MEM/WB match (wb_reg_write, addr != 0) -> 2; else 0; EX/MEM wins on double match.
REQ-021 Register 0 SHALL never cause a stall or forward.
REQ-022 Simultaneous load-use and md hazard SHALL resolve as MD_WAIT; load-use re-evaluated on exit.
REQ-023 Write-back-to-decode same-cycle hazard SHALL need no stall (register file writes before read).

Reset
REQ-024 rst_n low SHALL asynchronously force state RUN, md counter 0, md_busy 0.
REQ-025 During reset outputs SHALL be pc_write_en=1, ifid_write_en=1, idex_bubble=0, ifid_flush=0, fwd_a_sel=fwd_b_sel=0.
REQ-026 Reset mid-stall or mid-multiply SHALL abandon the operation; first cycle after release is RUN.

Structure
REQ-027 FSM state encoding and forward-select constants SHALL live in shared package cpu_pkg.
REQ-028 Mult/div busy counter SHALL be sub-module md_busy_counter; forwarding and FSM stay in hazard_control.

Verification
REQ-029 lw $2 in EX, add using $2 in ID -> exactly one cycle pc_write_en=0, idex_bubble=1, then RUN.
REQ-030 mem_write_addr=5, wb_write_addr=5, id_rs=5 with both writes -> fwd_a_sel=1; disable mem write -> 2.
REQ-031 mult issued with MD_LATENCY=32, mfhi next -> md_busy for 32 cycles, stall released the cycle md_busy falls.
REQ-032 ex_branch_taken asserted during LOAD_STALL -> ifid_flush=1, idex_bubble=1, FLUSH then RUN.
REQ-033 ex_mem_read with ex_write_addr=0 and id_rs=0 -> no stall, fwd_a_sel=0.
REQ-034 rst_n pulsed low at md counter=10 -> md_busy=0 immediately, RUN after release.
